// File: rtl/seg7_pkg.sv
// seg7_pkg
// Shared definitions for the multiplexed 7-segment driver:
//   - active-high glyph constants for hex digits 0-F, bit order {g,f,e,d,c,b,a}
//   - SEG_OFF, the active-high "all segments off" pattern
//   - scan_state_e, the scan FSM state encoding
package seg7_pkg;

  localparam logic [6:0] SEG_OFF = 7'h00;

  localparam logic [6:0] GLYPH_0 = 7'h3F;
  localparam logic [6:0] GLYPH_1 = 7'h06;
  localparam logic [6:0] GLYPH_2 = 7'h5B;
  localparam logic [6:0] GLYPH_3 = 7'h4F;
  localparam logic [6:0] GLYPH_4 = 7'h66;
  localparam logic [6:0] GLYPH_5 = 7'h6D;
  localparam logic [6:0] GLYPH_6 = 7'h7D;
  localparam logic [6:0] GLYPH_7 = 7'h07;
  localparam logic [6:0] GLYPH_8 = 7'h7F;
  localparam logic [6:0] GLYPH_9 = 7'h6F;
  localparam logic [6:0] GLYPH_A = 7'h77;
  localparam logic [6:0] GLYPH_B = 7'h7C;  // lowercase b
  localparam logic [6:0] GLYPH_C = 7'h39;
  localparam logic [6:0] GLYPH_D = 7'h5E;  // lowercase d
  localparam logic [6:0] GLYPH_E = 7'h79;
  localparam logic [6:0] GLYPH_F = 7'h71;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } scan_state_e;

endpackage

// File: rtl/seg7_hex_lut.sv
// seg7_hex_lut
// Purely combinational hex-to-7-segment decoder, active-high output.
// Ports:
//   nibble  in  4  hex value to display
//   glyph   out 7  segment pattern {g,f,e,d,c,b,a}, 1 = segment lit
module seg7_hex_lut
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] glyph
);

  always_comb begin
    glyph = SEG_OFF;
    case (nibble)
      4'h0: glyph = GLYPH_0;
      4'h1: glyph = GLYPH_1;
      4'h2: glyph = GLYPH_2;
      4'h3: glyph = GLYPH_3;
      4'h4: glyph = GLYPH_4;
      4'h5: glyph = GLYPH_5;
      4'h6: glyph = GLYPH_6;
      4'h7: glyph = GLYPH_7;
      4'h8: glyph = GLYPH_8;
      4'h9: glyph = GLYPH_9;
      4'hA: glyph = GLYPH_A;
      4'hB: glyph = GLYPH_B;
      4'hC: glyph = GLYPH_C;
      4'hD: glyph = GLYPH_D;
      4'hE: glyph = GLYPH_E;
      4'hF: glyph = GLYPH_F;
      default: glyph = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
// Time-multiplexed N-digit 7-segment driver with frame-coherent shadow
// registers, configurable dwell, anti-ghosting blank gap, per-digit decimal
// point, per-digit blank mask and live leading-zero suppression.
// Ports:
//   clk         in   1    system clock, rising edge
//   rst_n       in   1    asynchronous active-low reset
//   en          in   1    scan enable, 0 = display dark
//   load        in   1    strobe: capture digits_in / dp_in / blank_mask
//   digits_in   in   4*N  nibble k = hex value of digit k (digit 0 rightmost)
//   dp_in       in   N    decimal point request per digit
//   blank_mask  in   N    1 = force digit dark
//   lz_blank    in   1    1 = suppress leading zeros (not shadowed)
//   seg         out  7    segments a..g, polarity per SEG_ACTIVE_LOW
//   dp          out  1    decimal point, polarity per SEG_ACTIVE_LOW
//   an          out  N    one-hot digit select, polarity per AN_ACTIVE_LOW
//   frame_done  out  1    pulse after the last SHOW cycle of digit N-1
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int DWELL_CYCLES   = 50000,
  parameter int BLANK_CYCLES   = 2,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic                    lz_blank,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int MAX_CNT = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);
  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  localparam logic [6:0]            SEG_DARK = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic                  DP_DARK  = SEG_ACTIVE_LOW;
  localparam logic [NUM_DIGITS-1:0] AN_DARK  = AN_ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

  scan_state_e                 state_q, state_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic                        pending_q, pending_d;
  logic [4*NUM_DIGITS-1:0]     pend_digits_q, pend_digits_d;
  logic [NUM_DIGITS-1:0]       pend_dp_q, pend_dp_d;
  logic [NUM_DIGITS-1:0]       pend_mask_q, pend_mask_d;
  logic [4*NUM_DIGITS-1:0]     act_digits_q, act_digits_d;
  logic [NUM_DIGITS-1:0]       act_dp_q, act_dp_d;
  logic [NUM_DIGITS-1:0]       act_mask_q, act_mask_d;
  logic [6:0]                  seg_q, seg_d;
  logic                        dp_q, dp_d;
  logic [NUM_DIGITS-1:0]       an_q, an_d;
  logic                        frame_done_q, frame_done_d;

  logic                        frame_wrap;
  logic                        commit;
  logic [3:0]                  sel_nibble;
  logic                        sel_dp;
  logic                        sel_mask;
  logic                        upper_zero;
  logic                        dark;
  logic                        lit;
  logic [6:0]                  lut_glyph;
  logic [6:0]                  seg_raw;
  logic                        dp_raw;
  logic [NUM_DIGITS-1:0]       an_raw;

  // Scan sequencing: dropping en always returns to IDLE with the counters
  // cleared; the blank gap is skipped entirely when BLANK_CYCLES is 0.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    frame_wrap = 1'b0;
    if (!en) begin
      state_d = IDLE;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          idx_d = '0;
          cnt_d = '0;
          if (BLANK_CYCLES > 0) state_d = BLANK;
          else                  state_d = SHOW;
        end
        BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            cnt_d   = '0;
            state_d = SHOW;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        SHOW: begin
          if (cnt_q == DWELL_LAST) begin
            cnt_d = '0;
            if (BLANK_CYCLES > 0) state_d = BLANK;
            else                  state_d = SHOW;
            if (idx_q == IDX_LAST) begin
              idx_d      = '0;
              frame_wrap = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          idx_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Double-buffered digit data. New values wait in the pending shadow until
  // a frame boundary (or IDLE) so one frame never mixes old and new digits;
  // a load landing on the commit edge goes straight to the active shadow.
  always_comb begin
    pending_d     = pending_q;
    pend_digits_d = pend_digits_q;
    pend_dp_d     = pend_dp_q;
    pend_mask_d   = pend_mask_q;
    act_digits_d  = act_digits_q;
    act_dp_d      = act_dp_q;
    act_mask_d    = act_mask_q;
    commit        = frame_wrap || (state_q == IDLE);
    if (load) begin
      pend_digits_d = digits_in;
      pend_dp_d     = dp_in;
      pend_mask_d   = blank_mask;
    end
    if (commit) begin
      pending_d = 1'b0;
      if (load) begin
        act_digits_d = digits_in;
        act_dp_d     = dp_in;
        act_mask_d   = blank_mask;
      end else if (pending_q) begin
        act_digits_d = pend_digits_q;
        act_dp_d     = pend_dp_q;
        act_mask_d   = pend_mask_q;
      end
    end else if (load) begin
      pending_d = 1'b1;
    end
  end

  // Per-digit attributes are taken from the next-state index and the
  // next-state active shadow so the registered outputs line up with the FSM.
  always_comb begin
    sel_nibble = 4'h0;
    sel_dp     = 1'b0;
    sel_mask   = 1'b0;
    upper_zero = 1'b1;
    an_raw     = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (IDX_W'(k) == idx_d) begin
        sel_nibble = act_digits_d[k*4 +: 4];
        sel_dp     = act_dp_d[k];
        sel_mask   = act_mask_d[k];
        an_raw[k]  = 1'b1;
      end
      if ((k >= int'(idx_d)) && (act_digits_d[k*4 +: 4] != 4'h0)) begin
        upper_zero = 1'b0;
      end
    end
  end

  seg7_hex_lut u_hex_lut (
    .nibble (sel_nibble),
    .glyph  (lut_glyph)
  );

  // Blanking and polarity. Leading-zero suppression never darkens digit 0
  // and leaves the decimal point alone; the blank mask darkens both.
  always_comb begin
    lit          = (state_d == SHOW);
    dark         = sel_mask || (lz_blank && (idx_d != '0) && upper_zero);
    seg_raw      = (lit && !dark) ? lut_glyph : SEG_OFF;
    dp_raw       = lit && sel_dp && !sel_mask;
    seg_d        = SEG_ACTIVE_LOW ? ~seg_raw : seg_raw;
    dp_d         = SEG_ACTIVE_LOW ? ~dp_raw : dp_raw;
    an_d         = lit ? (AN_ACTIVE_LOW ? ~an_raw : an_raw) : AN_DARK;
    frame_done_d = frame_wrap;
  end

  // All state, shadows and output registers; reset forces every output to
  // its dark level and throws away any pending data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      cnt_q         <= '0;
      pending_q     <= 1'b0;
      pend_digits_q <= '0;
      pend_dp_q     <= '0;
      pend_mask_q   <= '0;
      act_digits_q  <= '0;
      act_dp_q      <= '0;
      act_mask_q    <= '0;
      seg_q         <= SEG_DARK;
      dp_q          <= DP_DARK;
      an_q          <= AN_DARK;
      frame_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      pending_q     <= pending_d;
      pend_digits_q <= pend_digits_d;
      pend_dp_q     <= pend_dp_d;
      pend_mask_q   <= pend_mask_d;
      act_digits_q  <= act_digits_d;
      act_dp_q      <= act_dp_d;
      act_mask_q    <= act_mask_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      an_q          <= an_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver
// Directed bench for seg7_scan_driver with N=4, DWELL=4, BLANK=1 and both
// outputs active-low. Every cycle of every frame is compared against
// hand-derived digit sequences and a locally typed glyph table.
module tb_seg7_scan_driver;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        load;
  logic [15:0] digits_in;
  logic [3:0]  dp_in;
  logic [3:0]  blank_mask;
  logic        lz_blank;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_done;

  int testsRun    = 0;
  int testsFailed = 0;

  seg7_scan_driver #(
    .NUM_DIGITS     (4),
    .DWELL_CYCLES   (4),
    .BLANK_CYCLES   (1),
    .SEG_ACTIVE_LOW (1'b1),
    .AN_ACTIVE_LOW  (1'b1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .load       (load),
    .digits_in  (digits_in),
    .dp_in      (dp_in),
    .blank_mask (blank_mask),
    .lz_blank   (lz_blank),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_done (frame_done)
  );

  // 10-unit clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Active-high reference glyphs {g..a}, typed in from the segment map.
  function automatic logic [6:0] glyphOf(input logic [3:0] n);
    case (n)
      4'h0: glyphOf = 7'h3F;
      4'h1: glyphOf = 7'h06;
      4'h2: glyphOf = 7'h5B;
      4'h3: glyphOf = 7'h4F;
      4'h4: glyphOf = 7'h66;
      4'h5: glyphOf = 7'h6D;
      4'h6: glyphOf = 7'h7D;
      4'h7: glyphOf = 7'h07;
      4'h8: glyphOf = 7'h7F;
      4'h9: glyphOf = 7'h6F;
      4'hA: glyphOf = 7'h77;
      4'hB: glyphOf = 7'h7C;
      4'hC: glyphOf = 7'h39;
      4'hD: glyphOf = 7'h5E;
      4'hE: glyphOf = 7'h79;
      default: glyphOf = 7'h71;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Queue a load strobe; the next step() consumes it.
  task automatic applyStimulus(input logic [15:0] d, input logic [3:0] dpv, input logic [3:0] m);
    digits_in  = d;
    dp_in      = dpv;
    blank_mask = m;
    load       = 1'b1;
  endtask

  // Advance one rising edge, sample 1 unit later, drop the load strobe.
  task automatic step;
    @(posedge clk);
    #1;
    load = 1'b0;
  endtask

  task automatic checkDark(input string tag, input logic fdExp);
    checkOutput({tag, "_an"}, 32'(an), 32'h0000000F);
    checkOutput({tag, "_seg"}, 32'(seg), 32'h0000007F);
    checkOutput({tag, "_dp"}, 32'(dp), 32'h00000001);
    checkOutput({tag, "_fd"}, 32'(frame_done), 32'(fdExp));
  endtask

  // One digit slot: a blank guard cycle followed by four lit cycles.
  task automatic showDigit(input int k, input logic [3:0] nib, input logic isDark,
                           input logic dpOn, input logic fd0);
    logic [3:0] anExp;
    logic [6:0] segExp;
    anExp  = ~(4'b0001 << k);
    segExp = isDark ? 7'h7F : ~glyphOf(nib);
    step;
    checkDark($sformatf("gap%0d", k), fd0);
    for (int c = 0; c < 4; c++) begin
      step;
      checkOutput($sformatf("d%0d_c%0d_an", k, c), 32'(an), 32'(anExp));
      checkOutput($sformatf("d%0d_c%0d_seg", k, c), 32'(seg), 32'(segExp));
      checkOutput($sformatf("d%0d_c%0d_dp", k, c), 32'(dp), 32'(!dpOn));
      checkOutput($sformatf("d%0d_c%0d_fd", k, c), 32'(frame_done), 32'h0);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    en         = 1'b0;
    load       = 1'b0;
    lz_blank   = 1'b0;
    digits_in  = 16'h0000;
    dp_in      = 4'h0;
    blank_mask = 4'h0;

    #12;
    checkDark("reset", 1'b0);
    rst_n = 1'b1;

    // Load while idle commits immediately; then start scanning 1234.
    applyStimulus(16'h1234, 4'b0000, 4'b0000);
    step;
    checkDark("idle", 1'b0);
    en = 1'b1;
    showDigit(0, 4'h4, 1'b0, 1'b0, 1'b0);
    showDigit(1, 4'h3, 1'b0, 1'b0, 1'b0);
    showDigit(2, 4'h2, 1'b0, 1'b0, 1'b0);
    showDigit(3, 4'h1, 1'b0, 1'b0, 1'b0);

    // Mid-frame load of ABCD must not disturb the current frame.
    showDigit(0, 4'h4, 1'b0, 1'b0, 1'b1);
    applyStimulus(16'hABCD, 4'b0000, 4'b0000);
    showDigit(1, 4'h3, 1'b0, 1'b0, 1'b0);
    showDigit(2, 4'h2, 1'b0, 1'b0, 1'b0);
    showDigit(3, 4'h1, 1'b0, 1'b0, 1'b0);

    showDigit(0, 4'hD, 1'b0, 1'b0, 1'b1);
    showDigit(1, 4'hC, 1'b0, 1'b0, 1'b0);
    showDigit(2, 4'hB, 1'b0, 1'b0, 1'b0);
    lz_blank = 1'b1;
    applyStimulus(16'h0070, 4'b0000, 4'b0000);
    showDigit(3, 4'hA, 1'b0, 1'b0, 1'b0);

    // Leading-zero suppression on 0070, then 0000.
    showDigit(0, 4'h0, 1'b0, 1'b0, 1'b1);
    showDigit(1, 4'h7, 1'b0, 1'b0, 1'b0);
    showDigit(2, 4'h0, 1'b1, 1'b0, 1'b0);
    applyStimulus(16'h0000, 4'b0000, 4'b0000);
    showDigit(3, 4'h0, 1'b1, 1'b0, 1'b0);

    showDigit(0, 4'h0, 1'b0, 1'b0, 1'b1);
    showDigit(1, 4'h0, 1'b1, 1'b0, 1'b0);
    showDigit(2, 4'h0, 1'b1, 1'b0, 1'b0);
    applyStimulus(16'h5678, 4'b0110, 4'b0100);
    showDigit(3, 4'h0, 1'b1, 1'b0, 1'b0);
    lz_blank = 1'b0;

    // Blank mask on digit 2 hides its dp; digit 1 dp lit.
    showDigit(0, 4'h8, 1'b0, 1'b0, 1'b1);
    showDigit(1, 4'h7, 1'b0, 1'b1, 1'b0);
    showDigit(2, 4'h6, 1'b1, 1'b0, 1'b0);
    showDigit(3, 4'h5, 1'b0, 1'b0, 1'b0);

    // Drop en for one cycle while digit 2 is selected.
    showDigit(0, 4'h8, 1'b0, 1'b0, 1'b1);
    showDigit(1, 4'h7, 1'b0, 1'b1, 1'b0);
    step;
    checkDark("gap2_pre_off", 1'b0);
    step;
    checkOutput("d2_pre_off_an", 32'(an), 32'hB);
    checkOutput("d2_pre_off_seg", 32'(seg), 32'h7F);
    en = 1'b0;
    step;
    checkDark("en_off", 1'b0);
    en = 1'b1;
    showDigit(0, 4'h8, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset mid-SHOW with a pending load that must be dropped.
    applyStimulus(16'h9999, 4'b0000, 4'b0000);
    step;
    checkDark("gap1_pre_rst", 1'b0);
    step;
    checkOutput("d1_pre_rst_an", 32'(an), 32'hD);
    checkOutput("d1_pre_rst_seg", 32'(seg), 32'(7'h78));
    #2;
    rst_n = 1'b0;
    #1;
    checkDark("async_rst", 1'b0);
    #3;
    rst_n = 1'b1;
    showDigit(0, 4'h0, 1'b0, 1'b0, 1'b0);
    showDigit(1, 4'h0, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Time-multiplexed driver for an N-digit common-anode/cathode 7-segment display. It is the parametrised successor of the single-digit hex decoder, and feeds the countdown and phase readouts of the traffic light controller. It holds a frame-coherent shadow copy of the digit values and scans the digits one at a time, with a configurable dwell and an anti-ghosting blank gap. It supports a per-digit decimal point, a per-digit blank mask and optional leading-zero suppression.

## Interface
Parameters:
- NUM_DIGITS, 4, digit count N (1..8)
- DWELL_CYCLES, 50000, clk cycles each digit is lit (≥1)
- BLANK_CYCLES, 2, all-off guard cycles before each digit (0 = no guard)
- SEG_ACTIVE_LOW, 1, 1: segment/dp outputs driven low = lit
- AN_ACTIVE_LOW, 1, 1: anode output low = digit selected

Ports:
- clk  in  1  system clock, all logic rising-edge
- rst_n  in  1  asynchronous active-low reset
- en  in  1  scan enable; 0 = display dark
- load  in  1  one-cycle strobe; capture digits_in/dp_in/blank_mask
- digits_in  in  4*N  nibble k = hex value of digit k (digit 0 = rightmost)
- dp_in  in  N  decimal point request per digit
- blank_mask  in  N  1 = force digit dark
- lz_blank  in  1  1 = suppress leading zeros (live, not shadowed)
- seg  out  7  segments, seg[0]=a … seg[6]=g
- dp  out  1  decimal point
- an  out  N  one-hot digit select
- frame_done  out  1  one-cycle pulse when digit N-1 finishes its dwell

## Operation
- Reset: state IDLE; idx=0; cnt=0; pending=0; active and pending shadows = 0. All outputs are inactive (seg, dp, an at their inactive level per polarity parameters), and frame_done=0.
- FSM states:
  - IDLE → (en=1 ? BLANK, or SHOW if BLANK_CYCLES=0) with idx=0.
  - BLANK: counts BLANK_CYCLES cycles, then → SHOW.
  - SHOW: counts DWELL_CYCLES cycles, then increments idx (wrapping N-1→0) and → BLANK (or SHOW if BLANK_CYCLES=0).
- en=0 in any state: the next edge goes to IDLE with idx=0, cnt=0 and outputs dark. Pending data is kept.
- Load/commit:
  - load copies the inputs into the pending shadow and sets pending=1. A later load before commit overwrites the earlier one.
  - Commit happens at the frame wrap (SHOW of idx N-1 ending) or on any cycle while in IDLE. Commit copies pending into the active shadow and clears pending.
  - If load coincides with a commit edge, the new input data is committed directly.
- Digit display in SHOW: nibble = active[idx], decoded through the hex LUT using standard 0-F glyphs (b and d lowercase). The digit is dark if any of these holds:
  - blank_mask[idx]=1;
  - lz_blank=1 and idx≠0 and all active nibbles at positions ≥ idx are 0.
- Dark digits still consume their slot, with an still asserted and seg/dp off.
- dp = active dp bit for idx; it is suppressed by blank_mask but not by lz_blank.
- Polarity is applied at the output register only.

## Timing
- seg, dp, an and frame_done are registered. Each is computed from the next state, so it changes on the same edge as the state transition.
- The first lit digit appears BLANK_CYCLES+1 edges after en is seen high in IDLE.
- Frame period = N*(BLANK_CYCLES+DWELL_CYCLES) cycles. Only one an bit is ever active, and never during BLANK.
- frame_done is high for the one cycle following the last SHOW cycle of idx N-1.
- Committed data takes effect from digit 0 of the next frame; no frame ever mixes old and new data.
- The reset assertion is asynchronous, and outputs go dark immediately. Reset mid-scan discards pending data. After release, the block restarts in IDLE.
- Counters are sized $clog2(max(DWELL_CYCLES,BLANK_CYCLES)+1) and $clog2(N), with explicit wrap at N-1 (N need not be a power of 2).

## Structure
- seg7_pkg holds:
  - the glyph constants for 0-F (active-high {g..a});
  - the FSM state enum (IDLE, BLANK, SHOW);
  - the SEG_OFF constant.
- Sub-module seg7_hex_lut: purely combinational 4→7 decoder, active-high, instantiated once on the selected nibble.
- Top level contains the FSM, prescaler, idx counter, shadows, blanking logic and output registers.

## Test plan
Bench parameters: N=4, DWELL=4, BLANK=1, active-low both.
- Reset then en=1, load digits_in=16'h1234, dp_in=0 → an cycles 1110, 1101, 1011, 0111. seg matches ~glyph(4), ~glyph(3), ~glyph(2), ~glyph(1). Each digit is lit 4 cycles with a 1-cycle all-off gap between digits. frame_done pulses every 20 cycles.
- load 16'hABCD mid-frame while idx=1 → the rest of the frame still shows 1234. The next frame begins with D at idx 0.
- lz_blank=1, digits 16'h0070 → digits 3 and 2 dark with an still stepping. Digit 1 shows 7, digit 0 shows 0. With digits 16'h0000, only digit 0 is lit, showing 0.
- blank_mask=4'b0100, dp_in=4'b0110 → digit 2 dark with dp off; digit 1 shows dp lit (dp=0).
- en dropped for 1 cycle at idx=2 → the next edge gives an=1111; on re-enable the scan restarts at idx 0 after 1 blank cycle.
- rst_n pulsed low mid-SHOW → outputs go to an=1111, seg=7'h7F, dp=1 before the next clk edge. The active shadow reads 0 after reset release.
